// File: rtl/ml_sweep_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ml_sweep_sched: sweeps all 256 4x4 QPSK candidates, tracks per-bit min costs, streams 8 max-log LLRs.
// Optional macro ML_LLR_SAT_EN saturates LLRs to LLR_W bits instead of truncating.
module ml_sweep_sched #(
   parameter int DATA_WIDTH = 20,
   parameter int QPSK_AMP   = 46341,
   parameter int CU_LAT     = 4,
   parameter int LLR_W      = 23
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   output logic                    o_busy,
   output logic [DATA_WIDTH-1:0]   o_s1_real,
   output logic [DATA_WIDTH-1:0]   o_s1_imag,
   output logic [DATA_WIDTH-1:0]   o_s2_real,
   output logic [DATA_WIDTH-1:0]   o_s2_imag,
   output logic [DATA_WIDTH-1:0]   o_s3_real,
   output logic [DATA_WIDTH-1:0]   o_s3_imag,
   output logic [DATA_WIDTH-1:0]   o_s4_real,
   output logic [DATA_WIDTH-1:0]   o_s4_imag,
   input  logic [DATA_WIDTH+1:0]   i_cost,
   output logic                    o_llr_valid,
   input  logic                    i_llr_ready,
   output logic [LLR_W-1:0]        o_llr,
   output logic [2:0]              o_llr_idx,
   output logic                    o_done
);
   localparam int CW = DATA_WIDTH + 2;
   localparam int DW = DATA_WIDTH + 3;
   localparam int SR = CU_LAT + 1;
   localparam logic [DATA_WIDTH-1:0] c_pos = DATA_WIDTH'(QPSK_AMP);
   localparam logic [DATA_WIDTH-1:0] c_neg = DATA_WIDTH'(-QPSK_AMP);

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_OUT} state_t;

   state_t                       r_state, w_next;
   logic [7:0]                   r_cnt;
   logic [7:0][DATA_WIDTH-1:0]   r_sym;
   logic [SR-1:0]                r_sv;
   logic [SR-1:0][7:0]           r_sidx;
   logic [7:0][CW-1:0]           r_min0, r_min1;
   logic [2:0]                   r_b;
   logic                         r_done;
   logic                         w_start, w_issue, w_acc, w_pv, w_busy, w_valid;
   logic [7:0]                   w_idx, w_pidx;
   logic signed [DW-1:0]         w_diff;
   logic [LLR_W-1:0]             w_llr;

   // a start coinciding with the o_done cycle is not accepted
   assign w_start = i_start && !r_done;
   assign w_issue = ((r_state == S_IDLE) && w_start) || (r_state == S_SWEEP);
   assign w_idx   = (r_state == S_SWEEP) ? r_cnt : 8'd0;
   assign w_pv    = r_sv[SR-1];
   assign w_pidx  = r_sidx[SR-1];
   assign w_acc   = (r_state == S_OUT) && i_llr_ready;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_busy  = 1'b1;
      w_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_start) w_next = S_SWEEP;
         end
         S_SWEEP: if (r_cnt == 8'd255) w_next = S_DRAIN;
         S_DRAIN: if (w_pv && (w_pidx == 8'd255)) w_next = S_OUT;
         S_OUT: begin
            w_valid = 1'b1;
            if (i_llr_ready && (r_b == 3'd7)) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt  <= '0;
         r_sym  <= '0;
         r_sv   <= '0;
         r_sidx <= '0;
         r_min0 <= '1;
         r_min1 <= '1;
         r_b    <= '0;
         r_done <= 1'b0;
      end else begin
         // {valid, index} rides alongside the cost pipeline
         r_sv   <= {r_sv[SR-2:0], w_issue};
         r_sidx <= {r_sidx[SR-2:0], w_idx};
         if (w_issue) begin
            r_cnt <= w_idx + 8'd1;
            for (int j = 0; j < 8; j++) r_sym[j] <= w_idx[j] ? c_neg : c_pos;
         end
         if ((r_state == S_IDLE) && w_start) begin
            r_min0 <= '1;
            r_min1 <= '1;
         end else if (w_pv) begin
            for (int b = 0; b < 8; b++) begin
               if (w_pidx[b]) begin
                  if (i_cost < r_min1[b]) r_min1[b] <= i_cost;
               end else begin
                  if (i_cost < r_min0[b]) r_min0[b] <= i_cost;
               end
            end
         end
         if (w_acc) r_b <= r_b + 3'd1;
         r_done <= w_acc && (r_b == 3'd7);
      end
   end

   assign w_diff = {1'b0, r_min1[r_b]} - {1'b0, r_min0[r_b]};

`ifdef ML_LLR_SAT_EN
   logic [DW-LLR_W:0] w_hi;
   assign w_hi = w_diff[DW-1:LLR_W-1];
   always_comb begin
      if ((w_hi == '0) || (w_hi == '1)) w_llr = w_diff[LLR_W-1:0];
      else if (w_diff[DW-1])            w_llr = {1'b1, {(LLR_W-1){1'b0}}};
      else                              w_llr = {1'b0, {(LLR_W-1){1'b1}}};
   end
`else
   assign w_llr = w_diff[LLR_W-1:0];
`endif

   assign o_busy      = w_busy;
   assign o_llr_valid = w_valid;
   assign o_llr       = w_valid ? w_llr : '0;
   assign o_llr_idx   = r_b;
   assign o_done      = r_done;
   assign o_s1_real   = r_sym[0];
   assign o_s1_imag   = r_sym[1];
   assign o_s2_real   = r_sym[2];
   assign o_s2_imag   = r_sym[3];
   assign o_s3_real   = r_sym[4];
   assign o_s3_imag   = r_sym[5];
   assign o_s4_real   = r_sym[6];
   assign o_s4_imag   = r_sym[7];
endmodule
`default_nettype wire

// File: tb/tb_ml_sweep_sched.sv
`default_nettype none
`timescale 1ns/1ps
// tb_ml_sweep_sched: scoreboard bench for ml_sweep_sched with a fixed-latency cost model.
// Honours ML_LLR_SAT_EN when computing expected LLRs.
module tb_ml_sweep_sched;
   localparam int DW = 20;
   localparam int LW = 16;
   localparam int CL = 4;
   localparam logic [DW-1:0] C_POS = 20'd46341;
   localparam logic [DW-1:0] C_NEG = 20'hF4AFB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b1;
   logic          o_busy, o_llr_valid, o_done;
   logic [DW-1:0] s1r, s1i, s2r, s2i, s3r, s3i, s4r, s4i;
   logic [DW+1:0] cost;
   logic [LW-1:0] o_llr;
   logic [2:0]    o_llr_idx;

   always #5 clk = ~clk;

   ml_sweep_sched #(.DATA_WIDTH(DW), .QPSK_AMP(46341), .CU_LAT(CL), .LLR_W(LW)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .o_busy(o_busy),
      .o_s1_real(s1r), .o_s1_imag(s1i), .o_s2_real(s2r), .o_s2_imag(s2i),
      .o_s3_real(s3r), .o_s3_imag(s3i), .o_s4_real(s4r), .o_s4_imag(s4i),
      .i_cost(cost), .o_llr_valid(o_llr_valid), .i_llr_ready(ready),
      .o_llr(o_llr), .o_llr_idx(o_llr_idx), .o_done(o_done)
   );

   logic [DW-1:0] s_arr [8];
   assign s_arr[0] = s1r; assign s_arr[1] = s1i; assign s_arr[2] = s2r; assign s_arr[3] = s2i;
   assign s_arr[4] = s3r; assign s_arr[5] = s3i; assign s_arr[6] = s4r; assign s_arr[7] = s4i;

   // cost model: a zero cost for one candidate, hi_cost for every other one
   logic [7:0]    zero_cand = 8'hA5;
   int            hi_cost = 1000;
   logic [7:0]    w_cand;
   logic [DW+1:0] cp [CL];
   always_comb begin
      w_cand = '0;
      for (int j = 0; j < 8; j++) w_cand[j] = s_arr[j][DW-1];
   end
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CL; i++) cp[i] <= '0;
      end else begin
         cp[0] <= (w_cand == zero_cand) ? '0 : (DW+2)'(hi_cost);
         for (int i = 1; i < CL; i++) cp[i] <= cp[i-1];
      end
   end
   assign cost = cp[CL-1];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int start_cyc = 0;
   int done_cnt = 0;
   bit lat_chk = 1'b0;
   logic prev_valid = 1'b0;

   typedef struct packed {
      logic [2:0]    idx;
      logic [LW-1:0] llr;
   } exp_t;
   exp_t q[$];
   exp_t e_mon;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [LW-1:0] model_llr(input int b);
      int v;
      v = zero_cand[b] ? -hi_cost : hi_cost;
`ifdef ML_LLR_SAT_EN
      if (v > (2**(LW-1)) - 1) v = (2**(LW-1)) - 1;
      if (v < -(2**(LW-1)))    v = -(2**(LW-1));
`endif
      return LW'(v);
   endfunction

   // monitor: pops the scoreboard on each handshake, checks first-LLR latency
   always @(negedge clk) begin
      if (rst) begin
         prev_valid <= 1'b0;
      end else begin
         if (o_llr_valid && !prev_valid && lat_chk)
            chk("latency", 64'(cyc - start_cyc), 64'(256 + CL));
         if (o_llr_valid && ready) begin
            chk("llr_pending", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               e_mon = q.pop_front();
               chk("llr_idx", 64'(o_llr_idx), 64'(e_mon.idx));
               chk("llr_val", 64'(o_llr), 64'(e_mon.llr));
            end
         end
         if (o_done) done_cnt++;
         prev_valid <= o_llr_valid;
      end
   end

   task automatic chk_idle_outputs(input string nm);
      chk({nm, "_ctrl"}, {o_busy, o_llr_valid, o_done, o_llr_idx}, 64'd0);
      chk({nm, "_llr"}, 64'(o_llr), 64'd0);
      for (int j = 0; j < 8; j++) chk({nm, "_sym"}, 64'(s_arr[j]), 64'd0);
   endtask

   task automatic run(input logic [7:0] zc, input int hi, input bit bp, input bit pulse);
      int   d0;
      bit   bp_done, out_pulsed, fin;
      exp_t e;
      bp_done = 1'b0; out_pulsed = 1'b0; fin = 1'b0;
      zero_cand = zc;
      hi_cost   = hi;
      for (int b = 0; b < 8; b++) begin
         e.idx = 3'(b);
         e.llr = model_llr(b);
         q.push_back(e);
      end
      d0 = done_cnt;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      start_cyc = cyc;
      lat_chk   = 1'b1;
      for (int j = 0; j < 8; j++) chk("cand0_sym", 64'(s_arr[j]), 64'(C_POS));
      @(posedge clk); #1;
      for (int j = 0; j < 8; j++) chk("cand1_sym", 64'(s_arr[j]), 64'((j == 0) ? C_NEG : C_POS));
      while (cyc < start_cyc + 255) begin
         @(posedge clk); #1;
         start = (pulse && (cyc == start_cyc + 50)) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      for (int j = 0; j < 8; j++) chk("cand255_sym", 64'(s_arr[j]), 64'(C_NEG));
      for (int n = 0; n < 64 && !fin; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done_cnt != d0) begin
            fin = 1'b1;
         end else if (bp && !bp_done && o_llr_valid && (o_llr_idx == 3'd3)) begin
            bp_done = 1'b1;
            ready   = 1'b0;
            repeat (10) begin
               @(posedge clk); #1;
               chk("bp_valid", 64'(o_llr_valid), 64'd1);
               chk("bp_idx", 64'(o_llr_idx), 64'd3);
               chk("bp_llr", 64'(o_llr), 64'(model_llr(3)));
            end
            ready = 1'b1;
         end else if (pulse && !out_pulsed && o_llr_valid && (o_llr_idx == 3'd5)) begin
            out_pulsed = 1'b1;
            start      = 1'b1;
         end
      end
      start = 1'b0;
      chk("done_seen", 64'(fin), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_count", 64'(done_cnt - d0), 64'd1);
      chk("busy_after", 64'(o_busy), 64'd0);
      chk("queue_empty", 64'(q.size()), 64'd0);
      lat_chk = 1'b0;
      q.delete();
   endtask

   task automatic abort_run();
      zero_cand = 8'hA5;
      hi_cost   = 1000;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      start_cyc = cyc;
      while (cyc < start_cyc + 100) begin
         @(posedge clk); #1;
      end
      chk("abort_busy_before", 64'(o_busy), 64'd1);
      rst = 1'b1;
      #1;
      chk_idle_outputs("abort");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk_idle_outputs("post_reset");
      run(8'hA5, 1000, 1'b0, 1'b0);
      run(8'hA5, 1000, 1'b1, 1'b1);
      abort_run();
      run(8'hA5, 1000, 1'b0, 1'b0);
      run(8'hFF, 200000, 1'b0, 1'b0);
      run(8'h00, 200000, 1'b0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
